// File: rtl/apb_reg_file.sv
// apb_reg_file: parametrised APB3 register-file slave.
// Holds NUM_REGS read/write registers with byte strobes. RO_MASK slots
// mirror hw_status and store nothing. PREADY can be delayed by a fixed
// number of wait states. Bad addresses and writes to RO slots complete
// with PSLVERR. Each committed write emits a one-cycle pulse per register.
module apb_reg_file #(
  parameter int unsigned          ADDR_WIDTH  = 8,
  parameter int unsigned          DATA_WIDTH  = 32,
  parameter int unsigned          NUM_REGS    = 16,
  parameter int unsigned          WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]  RO_MASK     = '0
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  input  logic [DATA_WIDTH/8-1:0]        PSTRB,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status
);

  localparam int unsigned NB     = DATA_WIDTH / 8;
  localparam int unsigned OB     = $clog2(NB);
  localparam int unsigned IW     = ADDR_WIDTH - OB;
  localparam logic [3:0]  WAIT_C = 4'(WAIT_STATES);

  // Register storage and bookkeeping flops.
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [3:0]            wcnt_q;
  logic [3:0]            wcnt_d;
  logic [NUM_REGS-1:0]   pulse_q;
  logic [NUM_REGS-1:0]   pulse_d;

  // Decode and handshake signals.
  logic [IW-1:0]         idx_s;
  logic [NUM_REGS-1:0]   sel_s;
  logic                  idx_oob_s;
  logic                  unaligned_s;
  logic                  ro_hit_s;
  logic                  err_s;
  logic                  access_s;
  logic                  pready_s;
  logic                  commit_s;
  logic [DATA_WIDTH-1:0] rdata_s;

  assign idx_s = PADDR[ADDR_WIDTH-1:OB];

  // The alignment check only exists when a register spans more than one byte.
  generate
    if (OB == 0) begin : g_no_align
      assign unaligned_s = 1'b0;
    end else begin : g_align
      assign unaligned_s = |PADDR[OB-1:0];
    end
  endgenerate

  // One-hot register select; an out-of-range index selects nothing.
  always_comb begin
    sel_s = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(idx_s) == 32'(i)) begin
        sel_s[i] = 1'b1;
      end else begin
        sel_s[i] = 1'b0;
      end
    end
  end

  // Error classification and APB handshake.
  always_comb begin
    idx_oob_s = (32'(idx_s) >= 32'(NUM_REGS));
    ro_hit_s  = |(sel_s & RO_MASK);
    err_s     = idx_oob_s | unaligned_s | (PWRITE & ro_hit_s);
    access_s  = PSEL & PENABLE;
    pready_s  = access_s & (wcnt_q == WAIT_C);
    commit_s  = pready_s & PWRITE & ~err_s;
  end

  // Wait counter: counts stalled ACCESS cycles, clears on completion or deselect.
  always_comb begin
    wcnt_d = wcnt_q;
    if (!PSEL || pready_s) begin
      wcnt_d = 4'd0;
    end else if (PENABLE) begin
      wcnt_d = wcnt_q + 4'd1;
    end else begin
      wcnt_d = wcnt_q;
    end
  end

  // Next register contents: strobe-merged write on commit; RO slots stay zero.
  always_comb begin
    pulse_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (RO_MASK[i]) begin
        regs_d[i] = '0;
      end else if (commit_s && sel_s[i]) begin
        for (int b = 0; b < NB; b++) begin
          if (PSTRB[b]) begin
            regs_d[i][b*8 +: 8] = PWDATA[b*8 +: 8];
          end else begin
            regs_d[i][b*8 +: 8] = regs_q[i][b*8 +: 8];
          end
        end
        pulse_d[i] = 1'b1;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Read mux: only driven on an error-free completing read.
  always_comb begin
    rdata_s = '0;
    if (pready_s && !PWRITE && !err_s) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (sel_s[i]) begin
          if (RO_MASK[i]) begin
            rdata_s = hw_status[i*DATA_WIDTH +: DATA_WIDTH];
          end else begin
            rdata_s = regs_q[i];
          end
        end else begin
          rdata_s = rdata_s;
        end
      end
    end else begin
      rdata_s = '0;
    end
  end

  // State update with synchronous active-low reset.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      wcnt_q  <= 4'd0;
      pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      wcnt_q  <= wcnt_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Flatten storage onto the core-facing bus.
  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end
  endgenerate

  assign reg_wr_pulse = pulse_q;
  assign PREADY       = pready_s;
  assign PSLVERR      = pready_s & err_s;
  assign PRDATA       = rdata_s;

endmodule

// File: tb/tb_apb_reg_file.sv
// tb_apb_reg_file: directed checks of apb_reg_file with three instances
// (0, 3 and 2 wait states) sharing one APB bus, each with its own PSEL.
module tb_apb_reg_file;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam int RW = NR * DW;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [3:0]    PSTRB;
  logic [RW-1:0] hw_status;
  logic [2:0]    psel;

  logic [DW-1:0] prdata_0, prdata_3, prdata_2;
  logic          pready_0, pready_3, pready_2;
  logic          pslverr_0, pslverr_3, pslverr_2;
  logic [RW-1:0] regq_0, regq_3, regq_2;
  logic [NR-1:0] pulse_0, pulse_3, pulse_2;

  logic [DW-1:0] m_prdata;
  logic          m_pready;
  logic          m_pslverr;
  int            cur;

  int n_tests;
  int n_fail;

  always #5 PCLK = ~PCLK;

  apb_reg_file #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
                 .WAIT_STATES(0), .RO_MASK(16'h0004)) u_ws0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[0]), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA(prdata_0), .PREADY(pready_0), .PSLVERR(pslverr_0),
    .reg_q(regq_0), .reg_wr_pulse(pulse_0), .hw_status(hw_status));

  apb_reg_file #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
                 .WAIT_STATES(3), .RO_MASK(16'h0000)) u_ws3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[1]), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA(prdata_3), .PREADY(pready_3), .PSLVERR(pslverr_3),
    .reg_q(regq_3), .reg_wr_pulse(pulse_3), .hw_status(hw_status));

  apb_reg_file #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
                 .WAIT_STATES(2), .RO_MASK(16'h0000)) u_ws2 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[2]), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA(prdata_2), .PREADY(pready_2), .PSLVERR(pslverr_2),
    .reg_q(regq_2), .reg_wr_pulse(pulse_2), .hw_status(hw_status));

  // View of the instance currently being addressed.
  always_comb begin
    case (cur)
      1: begin m_prdata = prdata_3; m_pready = pready_3; m_pslverr = pslverr_3; end
      2: begin m_prdata = prdata_2; m_pready = pready_2; m_pslverr = pslverr_2; end
      default: begin m_prdata = prdata_0; m_pready = pready_0; m_pslverr = pslverr_0; end
    endcase
  end

  task automatic check_val(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transfer; returns with the bus idle at posedge+1 so a
  // following call issued immediately is back-to-back.
  task automatic apb_xfer(input int d, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [3:0] strb,
                          output logic [DW-1:0] rdata, output logic slverr, output int waits);
    bit done;
    cur = d;
    psel = 3'b000;
    psel[d] = 1'b1;
    PENABLE = 1'b0;
    PWRITE = wr;
    PADDR = addr;
    PWDATA = wdata;
    PSTRB = strb;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waits = 0;
    done = 1'b0;
    rdata = '0;
    slverr = 1'b0;
    while (!done) begin
      @(negedge PCLK);
      if (m_pready) begin
        rdata = m_prdata;
        slverr = m_pslverr;
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 20) begin
          check_val("xfer_timeout", 1'b1, 1'b0);
          done = 1'b1;
        end
      end
      @(posedge PCLK); #1;
    end
    psel = 3'b000;
    PENABLE = 1'b0;
  endtask

  logic [DW-1:0] rd;
  logic          err;
  int            w;
  logic [RW-1:0] exp0;

  initial begin
    n_tests = 0;
    n_fail = 0;
    cur = 0;
    PRESETn = 1'b0;
    psel = 3'b000;
    PENABLE = 1'b0;
    PWRITE = 1'b0;
    PADDR = 8'h00;
    PWDATA = 32'h0;
    PSTRB = 4'h0;
    for (int i = 0; i < NR; i++) hw_status[i*DW +: DW] = 32'h5A5A0000 | 32'(i);
    hw_status[2*DW +: DW] = 32'hA5A5A5A5;
    exp0 = '0;

    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    @(negedge PCLK);
    check_val("rst_regq", regq_0, '0);
    check_val("rst_pulse", pulse_0, 16'h0000);
    check_val("rst_pready", pready_0, 1'b0);
    check_val("rst_pslverr", pslverr_0, 1'b0);
    check_val("rst_prdata", prdata_0, 32'h0);
    @(posedge PCLK); #1;

    // Basic write/read, back-to-back.
    apb_xfer(0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, rd, err, w);
    check_val("wr10_waits", 32'(w), 32'd0);
    check_val("wr10_err", err, 1'b0);
    check_val("wr10_pulse", pulse_0, 16'h0010);
    exp0[4*DW +: DW] = 32'hDEADBEEF;
    check_val("wr10_regq", regq_0, exp0);
    apb_xfer(0, 1'b0, 8'h10, 32'h0, 4'h0, rd, err, w);
    check_val("rd10_data", rd, 32'hDEADBEEF);
    check_val("rd10_err", err, 1'b0);
    check_val("rd10_waits", 32'(w), 32'd0);
    check_val("rd10_pulse_gone", pulse_0, 16'h0000);

    // Byte strobes.
    apb_xfer(0, 1'b1, 8'h20, 32'hCAFEBABE, 4'hF, rd, err, w);
    apb_xfer(0, 1'b1, 8'h20, 32'h11223344, 4'b0101, rd, err, w);
    check_val("strb_pulse", pulse_0, 16'h0100);
    apb_xfer(0, 1'b0, 8'h20, 32'h0, 4'h0, rd, err, w);
    check_val("strb_data", rd, 32'hCA22BA44);
    exp0[8*DW +: DW] = 32'hCA22BA44;

    // Error responses.
    apb_xfer(0, 1'b1, 8'h40, 32'hFFFFFFFF, 4'hF, rd, err, w);
    check_val("oob_err", err, 1'b1);
    check_val("oob_regq", regq_0, exp0);
    check_val("oob_pulse", pulse_0, 16'h0000);
    apb_xfer(0, 1'b1, 8'h11, 32'hFFFFFFFF, 4'hF, rd, err, w);
    check_val("unal_err", err, 1'b1);
    check_val("unal_regq", regq_0, exp0);
    apb_xfer(0, 1'b1, 8'h08, 32'hFFFFFFFF, 4'hF, rd, err, w);
    check_val("ro_wr_err", err, 1'b1);
    check_val("ro_wr_regq", regq_0, exp0);
    check_val("ro_wr_pulse", pulse_0, 16'h0000);
    apb_xfer(0, 1'b0, 8'h08, 32'h0, 4'h0, rd, err, w);
    check_val("ro_rd_data", rd, 32'hA5A5A5A5);
    check_val("ro_rd_err", err, 1'b0);
    apb_xfer(0, 1'b0, 8'h44, 32'h0, 4'h0, rd, err, w);
    check_val("oob_rd_err", err, 1'b1);
    check_val("oob_rd_data", rd, 32'h0);

    // Wait states = 3.
    apb_xfer(1, 1'b0, 8'h00, 32'h0, 4'h0, rd, err, w);
    check_val("ws3_waits", 32'(w), 32'd3);
    check_val("ws3_data", rd, 32'h0);
    check_val("ws3_err", err, 1'b0);

    // Aborted write on the 2-wait-state instance.
    apb_xfer(2, 1'b1, 8'h04, 32'h0BADF00D, 4'hF, rd, err, w);
    check_val("ws2_wr_waits", 32'(w), 32'd2);
    cur = 2;
    psel = 3'b100; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h04;
    PWDATA = 32'h12345678; PSTRB = 4'hF;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(negedge PCLK);
    check_val("abort_pready", pready_2, 1'b0);
    @(posedge PCLK); #1 psel = 3'b000; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    check_val("abort_pulse", pulse_2, 16'h0000);
    check_val("abort_reg1", regq_2[1*DW +: DW], 32'h0BADF00D);
    apb_xfer(2, 1'b0, 8'h04, 32'h0, 4'h0, rd, err, w);
    check_val("abort_rd_waits", 32'(w), 32'd2);
    check_val("abort_rd_data", rd, 32'h0BADF00D);
    check_val("abort_rd_err", err, 1'b0);

    // Reset in the middle of a waited transfer.
    cur = 2;
    psel = 3'b100; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h0C;
    PWDATA = 32'h00000055; PSTRB = 4'hF;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(posedge PCLK); #1 PRESETn = 1'b0;
    @(posedge PCLK); #1 PRESETn = 1'b1;
    check_val("mrst_regq2", regq_2, '0);
    check_val("mrst_regq0", regq_0, '0);
    check_val("mrst_pulse2", pulse_2, 16'h0000);
    @(negedge PCLK);
    check_val("mrst_pready", pready_2, 1'b0);
    @(posedge PCLK); #1 psel = 3'b000; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    apb_xfer(2, 1'b1, 8'h0C, 32'h00000055, 4'hF, rd, err, w);
    check_val("post_rst_wr_waits", 32'(w), 32'd2);
    check_val("post_rst_pulse", pulse_2, 16'h0008);
    apb_xfer(2, 1'b0, 8'h0C, 32'h0, 4'h0, rd, err, w);
    check_val("post_rst_rd_data", rd, 32'h00000055);
    apb_xfer(2, 1'b0, 8'h04, 32'h0, 4'h0, rd, err, w);
    check_val("post_rst_reg1", rd, 32'h0);
    apb_xfer(0, 1'b0, 8'h10, 32'h0, 4'h0, rd, err, w);
    check_val("post_rst_ws0_reg4", rd, 32'h0);
    check_val("post_rst_ws0_waits", 32'(w), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
